// File: rtl/clock_time_controller_if.sv
// Button inputs and sequencer pulses for the clock counter chain.
// The DUT uses the slave modport. The board or testbench uses the master modport.
interface clock_time_controller_if;
    logic       btn_mode;
    logic       btn_inc;
    logic       sec_tick;
    logic       min_inc;
    logic       hour_inc;
    logic       sec_clr;
    logic [1:0] mode;

    modport master (
        output btn_mode, btn_inc,
        input  sec_tick, min_inc, hour_inc, sec_clr, mode
    );

    modport slave (
        input  btn_mode, btn_inc,
        output sec_tick, min_inc, hour_inc, sec_clr, mode
    );
endinterface

// File: rtl/clock_time_controller.sv
// Digital clock sequencer.
// Divides clk down to a 1 Hz seconds tick and runs the RUN / SET_MIN / SET_HOUR mode FSM.
// It issues one-cycle increment and clear pulses to the external counter chain.
// Optional macro: CLOCK_CTRL_DEBOUNCE_EN adds a press-qualification counter per button.
module clock_time_controller #(
    parameter int unsigned TICKS_PER_SEC   = 100_000_000,
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic                   clk,
    input  logic                   reset,
    clock_time_controller_if.slave bus
);
    localparam int unsigned PW = $clog2(TICKS_PER_SEC);
    localparam int unsigned NB = 2;  // bit 0: mode button, bit 1: inc button

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        SET_MIN  = 2'b01,
        SET_HOUR = 2'b10
    } state_t;

    if (TICKS_PER_SEC < 2 || DEBOUNCE_CYCLES == 0) begin : g_param_check
        $error("clock_time_controller: TICKS_PER_SEC must be >= 2 and DEBOUNCE_CYCLES >= 1");
    end

    logic [NB-1:0] btn;
    logic [NB-1:0] q1;
    logic [NB-1:0] q2;
    logic [NB-1:0] q3;
    logic [NB-1:0] stable;
    logic [NB-1:0] press_c;
    logic          mode_press_c;
    logic          inc_press_c;

    state_t        state;
    state_t        state_c;
    logic [PW-1:0] presc;
    logic [PW-1:0] presc_c;
    logic          sec_tick;
    logic          sec_tick_c;
    logic          min_inc;
    logic          min_inc_c;
    logic          hour_inc;
    logic          hour_inc_c;
    logic          sec_clr;
    logic          sec_clr_c;

    assign btn = {bus.btn_inc, bus.btn_mode};

    // Two-flop synchronizer, plus an edge register on the qualified level.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q1 <= '0;
            q2 <= '0;
            q3 <= '0;
        end else begin
            q1 <= btn;
            q2 <= q1;
            q3 <= stable;
        end
    end

`ifdef CLOCK_CTRL_DEBOUNCE_EN
    localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [DW-1:0] deb_cnt [NB];

    // Count consecutive high cycles of the synchronized button; saturate at the accept threshold.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NB; i++) deb_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NB; i++) begin
                if (!q2[i])
                    deb_cnt[i] <= '0;
                else if (deb_cnt[i] != DW'(DEBOUNCE_CYCLES))
                    deb_cnt[i] <= deb_cnt[i] + DW'(1);
            end
        end
    end

    // A button counts as pressed only once it has been high for the full window.
    always_comb begin
        stable = '0;
        for (int i = 0; i < NB; i++) stable[i] = (deb_cnt[i] == DW'(DEBOUNCE_CYCLES));
    end
`else
    assign stable = q2;
`endif

    assign press_c      = stable & ~q3;
    assign mode_press_c = press_c[0];
    assign inc_press_c  = press_c[1];

    // State, prescaler and output pulse registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= RUN;
            presc    <= '0;
            sec_tick <= 1'b0;
            min_inc  <= 1'b0;
            hour_inc <= 1'b0;
            sec_clr  <= 1'b0;
        end else begin
            state    <= state_c;
            presc    <= presc_c;
            sec_tick <= sec_tick_c;
            min_inc  <= min_inc_c;
            hour_inc <= hour_inc_c;
            sec_clr  <= sec_clr_c;
        end
    end

    // Mode cycles RUN -> SET_MIN -> SET_HOUR -> RUN on each mode press.
    always_comb begin
        state_c = state;
        case (state)
            RUN:      if (mode_press_c) state_c = SET_MIN;
            SET_MIN:  if (mode_press_c) state_c = SET_HOUR;
            SET_HOUR: if (mode_press_c) state_c = RUN;
            default:  state_c = RUN;
        endcase
    end

    // Next values of the prescaler and pulses. A mode press shadows an inc press in the same cycle.
    always_comb begin
        presc_c    = '0;
        sec_tick_c = 1'b0;
        min_inc_c  = 1'b0;
        hour_inc_c = 1'b0;
        sec_clr_c  = 1'b0;
        case (state)
            RUN: begin
                if (presc == PW'(TICKS_PER_SEC - 1)) begin
                    sec_tick_c = 1'b1;
                end else begin
                    presc_c = presc + PW'(1);
                end
                if (mode_press_c) begin
                    sec_clr_c = 1'b1;
                    presc_c   = '0;
                end
            end
            SET_MIN:  min_inc_c  = inc_press_c & ~mode_press_c;
            SET_HOUR: hour_inc_c = inc_press_c & ~mode_press_c;
            default: ;
        endcase
    end

    assign bus.sec_tick = sec_tick;
    assign bus.min_inc  = min_inc;
    assign bus.hour_inc = hour_inc;
    assign bus.sec_clr  = sec_clr;
    assign bus.mode     = state;
endmodule

// File: tb/tb_clock_time_controller.sv
// Directed bench for clock_time_controller with an elapsed-time / press-history model.
module tb_clock_time_controller;
    localparam int T = 10;
    localparam int D = 4;
`ifdef CLOCK_CTRL_DEBOUNCE_EN
    localparam int LAG = 3 + D;  // age of the last low sample before a press
    localparam int NH  = D;      // count of high samples that must follow it
    localparam int PW  = D + 2;  // width of a well-formed press
`else
    localparam int LAG = 3;
    localparam int NH  = 1;
    localparam int PW  = 1;
`endif
    localparam int LAT = LAG - 1;  // edges from the first high sample to the output change

    logic clk = 1'b0;
    logic reset = 1'b1;
    clock_time_controller_if bus ();

    clock_time_controller #(.TICKS_PER_SEC(T), .DEBOUNCE_CYCLES(D)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int n_tick = 0, n_min = 0, n_hour = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: button sample histories indexed by age, mode, and cycles spent in RUN.
    logic [15:0] hm = '0, hi = '0;
    int  m_mode = 0, run_cyc = 0;
    int  e_tick = 0, e_min = 0, e_hour = 0, e_clr = 0;

    function automatic logic pressed(input logic [15:0] h);
        logic ok;
        ok = !h[LAG];
        for (int a = LAG - NH; a < LAG; a++) ok = ok & h[a];
        return ok;
    endfunction

    always @(posedge clk) begin
        logic pm, pi;
        e_tick = 0; e_min = 0; e_hour = 0; e_clr = 0;
        if (reset) begin
            hm = '0; hi = '0; m_mode = 0; run_cyc = 0;
        end else begin
            hm = {hm[14:0], bus.btn_mode};
            hi = {hi[14:0], bus.btn_inc};
            pm = pressed(hm);
            pi = pressed(hi);
            case (m_mode)
                0: begin
                    run_cyc++;
                    if (run_cyc == T) begin e_tick = 1; run_cyc = 0; end
                    if (pm) begin e_clr = 1; m_mode = 1; run_cyc = 0; end
                end
                1: if (pm) m_mode = 2; else if (pi) e_min = 1;
                default: if (pm) begin m_mode = 0; run_cyc = 0; end else if (pi) e_hour = 1;
            endcase
        end
    end

    // Per-cycle comparison against the model, plus pulse tallies.
    always @(posedge clk) begin
        #1;
        chk("sec_tick", int'(bus.sec_tick), e_tick);
        chk("min_inc",  int'(bus.min_inc),  e_min);
        chk("hour_inc", int'(bus.hour_inc), e_hour);
        chk("sec_clr",  int'(bus.sec_clr),  e_clr);
        chk("mode",     int'(bus.mode),     m_mode);
        chk("onehot", int'((32'(bus.sec_tick) + 32'(bus.min_inc) + 32'(bus.hour_inc)) > 1), 0);
        chk("clr_vs_inc", int'(bus.sec_clr & (bus.min_inc | bus.hour_inc)), 0);
        if (bus.sec_tick) n_tick++;
        if (bus.min_inc)  n_min++;
        if (bus.hour_inc) n_hour++;
    end

    task automatic wait_edges(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic press(input logic m, input logic i, input int len);
        @(negedge clk);
        bus.btn_mode = m;
        bus.btn_inc  = i;
        repeat (len) @(negedge clk);
        bus.btn_mode = 1'b0;
        bus.btn_inc  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, m0, h0;
        bus.btn_mode = 1'b0;
        bus.btn_inc  = 1'b0;

        // Reset held for three cycles.
        repeat (3) @(posedge clk);
        #2;
        chk("rst_mode", int'(bus.mode), 0);
        chk("rst_tick", int'(bus.sec_tick), 0);
        @(negedge clk) reset = 1'b0;
        t0 = n_tick;
        wait_edges(9);
        chk("tick_edge9", int'(bus.sec_tick), 0);
        wait_edges(1);
        chk("tick_edge10", int'(bus.sec_tick), 1);
        wait_edges(20);
        chk("ticks_in_30", n_tick - t0, 3);

`ifdef CLOCK_CTRL_DEBOUNCE_EN
        // A short glitch must be ignored.
        press(1'b1, 1'b0, 3);
        wait_edges(15);
        chk("glitch_mode", int'(bus.mode), 0);
`endif

        // Enter SET_MIN.
        press(1'b1, 1'b0, PW);
        wait_edges(LAT - PW);
        chk("mode_before", int'(bus.mode), 0);
        wait_edges(1);
        chk("mode_setmin", int'(bus.mode), 1);
        chk("sec_clr_on", int'(bus.sec_clr), 1);
        wait_edges(1);
        chk("sec_clr_off", int'(bus.sec_clr), 0);
        t0 = n_tick;
        wait_edges(50);
        chk("no_tick_setmin", n_tick - t0, 0);

        // Three inc presses in SET_MIN.
        m0 = n_min; h0 = n_hour;
        for (int k = 0; k < 3; k++) begin
            press(1'b0, 1'b1, PW + 1);
            idle(6);
        end
        wait_edges(10);
        chk("min_count3", n_min - m0, 3);
        chk("hour_count0", n_hour - h0, 0);

        // Two mode presses lead back to RUN, with the first tick T cycles later.
        press(1'b1, 1'b0, PW);
        idle(8);
        wait_edges(1);
        chk("mode_sethour", int'(bus.mode), 2);
        press(1'b1, 1'b0, PW);
        wait_edges(LAT - PW + 1);
        chk("mode_run", int'(bus.mode), 0);
        wait_edges(T - 1);
        chk("tick_T_minus1", int'(bus.sec_tick), 0);
        wait_edges(1);
        chk("tick_T", int'(bus.sec_tick), 1);

        // Mode and inc rising together in SET_HOUR.
        press(1'b1, 1'b0, PW);
        idle(8);
        press(1'b1, 1'b0, PW);
        idle(8);
        wait_edges(1);
        chk("mode_sethour2", int'(bus.mode), 2);
        h0 = n_hour;
        press(1'b1, 1'b1, PW);
        wait_edges(LAT - PW + 1);
        chk("simul_mode", int'(bus.mode), 0);
        wait_edges(8);
        chk("simul_no_hour", n_hour - h0, 0);

        // A held inc press gives one pulse only.
        press(1'b1, 1'b0, PW);
        idle(8);
        wait_edges(1);
        chk("mode_setmin2", int'(bus.mode), 1);
        m0 = n_min;
        press(1'b0, 1'b1, 40);
        idle(8);
        chk("held_one_pulse", n_min - m0, 1);

        // Reset asserted mid-hold.
        @(negedge clk) bus.btn_inc = 1'b1;
        idle(10);
        reset = 1'b1;
        #1;
        chk("async_mode", int'(bus.mode), 0);
        chk("async_tick", int'(bus.sec_tick), 0);
        chk("async_min", int'(bus.min_inc), 0);
        chk("async_clr", int'(bus.sec_clr), 0);
        idle(3);
        bus.btn_inc = 1'b0;
        @(negedge clk) reset = 1'b0;
        wait_edges(T);
        chk("post_rst_mode", int'(bus.mode), 0);
        chk("post_rst_tick", int'(bus.sec_tick), 1);
        wait_edges(5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
